// File: rtl/sfb_pkg.sv
// Shared types and helpers for the store-to-load forwarding buffer:
// store size codes, the buffer entry record, byte-lane mask and alignment.
package sfb_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } sfb_size_e;

  // Word address field covers byte addresses up to 32 bits; age covers RETIRE_LAT up to 255.
  localparam int SFB_WADDR_W = 30;
  localparam int SFB_AGE_W   = 8;

  typedef struct packed {
    logic                   valid;
    logic [SFB_WADDR_W-1:0] waddr;
    logic [3:0]             mask;
    logic [31:0]            data;
    logic [SFB_AGE_W-1:0]   age;
  } sfb_entry_t;

  // Misaligned half/word accesses yield an empty mask so they never enter the buffer.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] m;
    m = 4'h0;
    case (sfb_size_e'(size))
      SZ_B:    m = 4'b0001 << a;
      SZ_H:    if (!a[0]) m = 4'b0011 << a;
      SZ_W:    if (a == 2'd0) m = 4'hF;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_align(input logic [31:0] data, input logic [1:0] a);
    return data << {a, 3'b000};
  endfunction

endpackage

// File: rtl/sfb_lane_merge.sv
// Per-byte-lane youngest-match select over the buffer entries plus the
// same-cycle store bypass slot, which always counts as youngest.
module sfb_lane_merge
  import sfb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sfb_entry_t [DEPTH-1:0]   entries,
  input  logic                     byp_valid,
  input  logic [SFB_WADDR_W-1:0]   byp_waddr,
  input  logic [3:0]               byp_mask,
  input  logic [31:0]              byp_data,
  input  logic [SFB_WADDR_W-1:0]   ld_waddr,
  output logic [3:0]               mask,
  output logic [31:0]              data
);

  logic                 found;
  logic [SFB_AGE_W-1:0] best_age;

  // Entries are only ever written with age 0 on an aging edge, so live ages are distinct
  // and the smallest age is the most recently inserted entry.
  always_comb begin
    mask     = 4'h0;
    data     = 32'h0;
    found    = 1'b0;
    best_age = '1;
    for (int l = 0; l < 4; l++) begin
      found    = 1'b0;
      best_age = '1;
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].valid && (entries[i].waddr == ld_waddr) && entries[i].mask[l] &&
            (!found || (entries[i].age < best_age))) begin
          found            = 1'b1;
          best_age         = entries[i].age;
          data[l*8 +: 8]   = entries[i].data[l*8 +: 8];
        end
      end
      if (byp_valid && (byp_waddr == ld_waddr) && byp_mask[l]) begin
        found          = 1'b1;
        data[l*8 +: 8] = byp_data[l*8 +: 8];
      end
      mask[l] = found;
    end
  end

endmodule

// File: rtl/store_forward_buffer.sv
// Store-to-load forwarding buffer: holds in-flight stores for RETIRE_LAT cycles and
// forwards their newest bytes to loads. Define SFB_STATS_EN to build the hit/full counters.
module store_forward_buffer
  import sfb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 32,
  parameter int RETIRE_LAT = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [1:0]                 st_size,
  input  logic [31:0]                st_data,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       fwd_valid,
  output logic [3:0]                 fwd_mask,
  output logic [31:0]                fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                hit_count,
  output logic [31:0]                full_stall_count
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  // With RETIRE_LAT of 1 a store is only visible through the bypass and is never held.
  localparam bit HOLDS = (RETIRE_LAT >= 2);
  localparam logic [SFB_AGE_W-1:0] RET_AGE = SFB_AGE_W'((RETIRE_LAT >= 2) ? RETIRE_LAT - 2 : 0);

  logic [DEPTH-1:0]       vld_q;
  logic [SFB_AGE_W-1:0]   age_q   [DEPTH];
  logic [SFB_WADDR_W-1:0] waddr_q [DEPTH];
  logic [3:0]             mask_q  [DEPTH];
  logic [31:0]            data_q  [DEPTH];

  logic [DEPTH-1:0]       retiring;
  logic [DEPTH-1:0]       slot_oh;
  logic                   slot_found;
  logic [OCC_W-1:0]       occ;
  logic                   accept;
  logic                   insert;
  logic [3:0]             st_mask;
  logic [31:0]            st_lanes;
  logic [SFB_WADDR_W-1:0] st_waddr;
  logic [SFB_WADDR_W-1:0] ld_waddr;
  sfb_entry_t [DEPTH-1:0] entries;
  logic [3:0]             merge_mask;
  logic [31:0]            merge_data;
  logic                   vld_p1;
  logic [3:0]             fwd_mask_p1;
  logic [31:0]            fwd_data_p1;
  logic                   unused_ld_lsb;

  assign st_mask       = byte_mask(st_size, st_addr[1:0]);
  assign st_lanes      = lane_align(st_data, st_addr[1:0]);
  assign st_waddr      = SFB_WADDR_W'(st_addr[ADDR_W-1:2]);
  assign ld_waddr      = SFB_WADDR_W'(ld_addr[ADDR_W-1:2]);
  assign unused_ld_lsb = ^ld_addr[1:0];

  always_comb begin
    occ        = '0;
    retiring   = '0;
    slot_oh    = '0;
    slot_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occ         = occ + OCC_W'(vld_q[i]);
      retiring[i] = vld_q[i] && !stall && (age_q[i] == RET_AGE);
      if (!slot_found && (!vld_q[i] || retiring[i])) begin
        slot_oh[i] = 1'b1;
        slot_found = 1'b1;
      end
    end
  end

  assign occupancy = occ;
  assign st_ready  = !stall && ((occ < OCC_W'(DEPTH)) || (|retiring));
  assign accept    = st_valid && st_ready;
  assign insert    = HOLDS && accept && (st_mask != 4'h0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (!stall) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (insert && slot_oh[i]) begin
          vld_q[i] <= 1'b1;
          age_q[i] <= '0;
        end else if (retiring[i]) begin
          vld_q[i] <= 1'b0;
        end else if (vld_q[i]) begin
          age_q[i] <= age_q[i] + SFB_AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (insert && slot_oh[i]) begin
        waddr_q[i] <= st_waddr;
        mask_q[i]  <= st_mask;
        data_q[i]  <= st_lanes;
      end
    end
  end

  always_comb begin
    entries = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i].valid = vld_q[i];
      entries[i].waddr = waddr_q[i];
      entries[i].mask  = mask_q[i];
      entries[i].data  = data_q[i];
      entries[i].age   = age_q[i];
    end
  end

  sfb_lane_merge #(
    .DEPTH (DEPTH)
  ) u_lane_merge (
    .entries   (entries),
    .byp_valid (accept),
    .byp_waddr (st_waddr),
    .byp_mask  (st_mask),
    .byp_data  (st_lanes),
    .ld_waddr  (ld_waddr),
    .mask      (merge_mask),
    .data      (merge_data)
  );

  // p1: registered lookup result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1      <= 1'b0;
      fwd_mask_p1 <= 4'h0;
      fwd_data_p1 <= 32'h0;
    end else begin
      vld_p1      <= ld_valid;
      fwd_mask_p1 <= ld_valid ? merge_mask : 4'h0;
      fwd_data_p1 <= ld_valid ? merge_data : 32'h0;
    end
  end

  assign fwd_valid = vld_p1;
  assign fwd_mask  = fwd_mask_p1;
  assign fwd_data  = fwd_data_p1;

`ifdef SFB_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] full_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q  <= 32'h0;
      full_q <= 32'h0;
    end else begin
      if (ld_valid && (merge_mask != 4'h0)) hit_q <= hit_q + 32'd1;
      if (st_valid && !st_ready && !stall) full_q <= full_q + 32'd1;
    end
  end

  assign hit_count        = hit_q;
  assign full_stall_count = full_q;
`else
  assign hit_count        = 32'h0;
  assign full_stall_count = 32'h0;
`endif

endmodule
